// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory controller: turns a MAR/MDR request into a wait-stated async-SRAM
// cycle, or services the memory-mapped I/O word (switches / hex display register).
module slc3_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] MAR_IN,
  input  logic [15:0] MDR_IN,
  input  logic [15:0] SW,
  input  logic [15:0] SRAM_DQ_IN,
  output logic [15:0] MEM_RDATA,
  output logic        MEM_R,
  output logic [15:0] HEX_OUT,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic        we_q;
  logic [15:0] rdata_q;
  logic        r_q;
  logic [15:0] hex_q;
  logic [19:0] addr_q;
  logic [15:0] dq_out_q;
  logic        dq_oe_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        ub_n_q;
  logic        lb_n_q;

  assign cnt_d = cnt_q + 4'd1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      rdata_q  <= 16'h0000;
      r_q      <= 1'b0;
      hex_q    <= 16'h0000;
      addr_q   <= 20'h00000;
      dq_out_q <= 16'h0000;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
    end else begin
      r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MEM_REQ) begin
            we_q <= MEM_WE;
            if (MAR_IN == IO_ADDR) begin
              // I/O word completes immediately and never touches the SRAM pins
              state_q <= DONE;
              r_q     <= 1'b1;
              if (MEM_WE) begin
                hex_q <= MDR_IN;
              end else begin
                rdata_q <= SW;
              end
            end else begin
              state_q  <= SETUP;
              addr_q   <= {4'h0, MAR_IN};
              dq_out_q <= MDR_IN;
              dq_oe_q  <= MEM_WE;
              ce_n_q   <= 1'b0;
              ub_n_q   <= 1'b0;
              lb_n_q   <= 1'b0;
            end
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= 4'd0;
          if (we_q) begin
            we_n_q <= 1'b0;
          end else begin
            oe_n_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            r_q     <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            if (!we_q) begin
              rdata_q <= SRAM_DQ_IN;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          // address/data were held through DONE; release the bus on the way out
          state_q <= IDLE;
          ce_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MEM_RDATA   = rdata_q;
  assign MEM_R       = r_q;
  assign HEX_OUT     = hex_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_OUT = dq_out_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = ub_n_q;
  assign SRAM_LB_N   = lb_n_q;

  a_no_oe_we_overlap: assert property (@(posedge Clk) disable iff (!Reset)
    !(!oe_n_q && !we_n_q));
  a_dq_oe_write_only: assert property (@(posedge Clk) disable iff (!Reset)
    dq_oe_q |-> we_q);

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Bench for slc3_mem_ctrl: three instances (WAIT_CYCLES 2, 1, 15) share stimulus,
// each with its own SRAM model; directed vectors plus a short random scoreboard run.
module tb_slc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] sw;

  logic [15:0] rdata_w [3];
  logic        r_w     [3];
  logic [15:0] hex_w   [3];
  logic [19:0] addr_w  [3];
  logic [15:0] dqo_w   [3];
  logic        dqoe_w  [3];
  logic        ce_w    [3];
  logic        oe_w    [3];
  logic        we_w    [3];
  logic        ub_w    [3];
  logic        lb_w    [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int unsigned WC = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
      logic [15:0] mem [256] = '{default: 16'h0000};
      logic [15:0] dqi;

      slc3_mem_ctrl #(.WAIT_CYCLES(WC), .IO_ADDR(16'hFFFF)) u_dut (
        .Clk(clk), .Reset(rst_n), .MEM_REQ(mem_req), .MEM_WE(mem_we),
        .MAR_IN(mar), .MDR_IN(mdr), .SW(sw), .SRAM_DQ_IN(dqi),
        .MEM_RDATA(rdata_w[gi]), .MEM_R(r_w[gi]), .HEX_OUT(hex_w[gi]),
        .SRAM_ADDR(addr_w[gi]), .SRAM_DQ_OUT(dqo_w[gi]), .SRAM_DQ_OE(dqoe_w[gi]),
        .SRAM_CE_N(ce_w[gi]), .SRAM_OE_N(oe_w[gi]), .SRAM_WE_N(we_w[gi]),
        .SRAM_UB_N(ub_w[gi]), .SRAM_LB_N(lb_w[gi])
      );

      // Async SRAM model: drives data only while selected and output-enabled
      assign dqi = (!ce_w[gi] && !oe_w[gi]) ? mem[addr_w[gi][7:0]] : 16'hDEAD;
      always @(posedge clk) begin
        if (!ce_w[gi] && !we_w[gi] && dqoe_w[gi]) mem[addr_w[gi][7:0]] <= dqo_w[gi];
      end
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  int          lat      [3];
  int          r_cnt    [3];
  int          oe_cnt   [3];
  int          we_cnt   [3];
  int          ce_cnt   [3];
  int          both_cnt [3];
  int          dqoe_cnt [3];
  int          dqm_cnt  [3];
  logic [15:0] rd_at_r  [3];
  logic [19:0] addr_s   [3];

  logic [15:0] sb [256];
  logic [15:0] exp_rd [3];
  logic [15:0] exp_hex;
  logic [15:0] addr_tab [8];
  int          txn_no = 0;

  function automatic int wc_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request and samples every instance each cycle until all have completed
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] data);
    int  c;
    logic done_all;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; r_cnt[i] = 0; oe_cnt[i] = 0; we_cnt[i] = 0; ce_cnt[i] = 0;
      both_cnt[i] = 0; dqoe_cnt[i] = 0; dqm_cnt[i] = 0; rd_at_r[i] = 16'h0; addr_s[i] = 20'h0;
    end
    mem_req = 1'b1; mem_we = we; mar = addr; mdr = data;
    c = 0;
    done_all = 1'b0;
    while (!done_all && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) mem_req = 1'b0;
      done_all = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!oe_w[i]) oe_cnt[i]++;
        if (!we_w[i]) we_cnt[i]++;
        if (!ce_w[i]) ce_cnt[i]++;
        if (!oe_w[i] && !we_w[i]) both_cnt[i]++;
        if (dqoe_w[i]) begin
          dqoe_cnt[i]++;
          if (dqo_w[i] == data) dqm_cnt[i]++;
        end
        if (c == 1) addr_s[i] = addr_w[i];
        if (r_w[i]) begin
          r_cnt[i]++;
          if (lat[i] == 0) begin
            lat[i] = c;
            rd_at_r[i] = rdata_w[i];
          end
        end
        if (lat[i] == 0) done_all = 1'b0;
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (!ce_w[i] || !dqoe_w[i] == 1'b0 || r_w[i]) begin
        ce_cnt[i]++;
        if (r_w[i]) r_cnt[i]++;
        if (dqoe_w[i]) dqoe_cnt[i]++;
      end
    end
  endtask

  task automatic txn_check(input logic we, input logic [15:0] addr, input logic [15:0] data);
    logic is_io;
    int   w;
    is_io = (addr == 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      if (!we) exp_rd[i] = is_io ? sw : sb[addr[7:0]];
    end
    if (we && is_io) exp_hex = data;
    run_txn(we, addr, data);
    for (int i = 0; i < 3; i++) begin
      w = wc_of(i);
      check_eq($sformatf("lat[%0d]", i), lat[i], is_io ? 1 : w + 2);
      check_eq($sformatf("r_pulses[%0d]", i), r_cnt[i], 1);
      check_eq($sformatf("oe_we_overlap[%0d]", i), both_cnt[i], 0);
      check_eq($sformatf("rdata[%0d]", i), rd_at_r[i], exp_rd[i]);
      check_eq($sformatf("hex[%0d]", i), hex_w[i], exp_hex);
      if (is_io) begin
        check_eq($sformatf("io_ce_low[%0d]", i), ce_cnt[i], 0);
        check_eq($sformatf("io_dqoe[%0d]", i), dqoe_cnt[i], 0);
      end else begin
        check_eq($sformatf("ce_low[%0d]", i), ce_cnt[i], w + 2);
        check_eq($sformatf("sram_addr[%0d]", i), addr_s[i], {4'h0, addr});
        if (we) begin
          check_eq($sformatf("we_low[%0d]", i), we_cnt[i], w);
          check_eq($sformatf("wr_oe_low[%0d]", i), oe_cnt[i], 0);
          check_eq($sformatf("dqoe[%0d]", i), dqoe_cnt[i], w + 2);
          check_eq($sformatf("dq_out[%0d]", i), dqm_cnt[i], w + 2);
        end else begin
          check_eq($sformatf("oe_low[%0d]", i), oe_cnt[i], w);
          check_eq($sformatf("rd_we_low[%0d]", i), we_cnt[i], 0);
          check_eq($sformatf("rd_dqoe[%0d]", i), dqoe_cnt[i], 0);
        end
      end
    end
    if (we && !is_io) sb[addr[7:0]] = data;
    txn_no++;
    $display("txn %0d we=%0b addr=%h data=%h lat=%0d/%0d/%0d rdata=%h/%h/%h hex=%h",
             txn_no, we, addr, data, lat[0], lat[1], lat[2],
             rd_at_r[0], rd_at_r[1], rd_at_r[2], hex_w[0]);
  endtask

  initial begin
    int          c;
    int          p_cnt;
    int          t1, t2;
    logic [15:0] d1, d2;
    int          stray;
    logic        we_r;
    logic [15:0] a_r;

    for (int k = 0; k < 256; k++) sb[k] = 16'h0000;
    for (int i = 0; i < 3; i++) exp_rd[i] = 16'h0000;
    exp_hex = 16'h0000;
    addr_tab[0] = 16'h0010; addr_tab[1] = 16'h1021; addr_tab[2] = 16'h2032; addr_tab[3] = 16'h4043;
    addr_tab[4] = 16'h3000; addr_tab[5] = 16'h0042; addr_tab[6] = 16'hFFFE; addr_tab[7] = 16'hFFFF;

    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mar = 16'h0; mdr = 16'h0; sw = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_rdata[%0d]", i), rdata_w[i], 16'h0000);
      check_eq($sformatf("rst_hex[%0d]", i), hex_w[i], 16'h0000);
      check_eq($sformatf("rst_addr[%0d]", i), addr_w[i], 20'h00000);
      check_eq($sformatf("rst_dqout[%0d]", i), dqo_w[i], 16'h0000);
      check_eq($sformatf("rst_ctl[%0d]", i),
               {r_w[i], dqoe_w[i], ce_w[i], oe_w[i], we_w[i], ub_w[i], lb_w[i]}, 7'b0011111);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic SRAM read/write, read-back, FFFE as ordinary SRAM
    txn_check(1'b1, 16'h3000, 16'h1234);
    txn_check(1'b0, 16'h3000, 16'h0000);
    txn_check(1'b1, 16'h0042, 16'hBEEF);
    txn_check(1'b0, 16'h0042, 16'h0000);
    txn_check(1'b1, 16'hFFFE, 16'hC0DE);
    txn_check(1'b0, 16'hFFFE, 16'h0000);

    // Memory-mapped I/O
    txn_check(1'b1, 16'hFFFF, 16'h00A5);
    sw = 16'h0301;
    txn_check(1'b0, 16'hFFFF, 16'h0000);

    // REQ held high across two reads; MAR changes during the first
    mem_req = 1'b1; mem_we = 1'b0; mar = 16'h3000; mdr = 16'h0;
    p_cnt = 0; t1 = 0; t2 = 0; d1 = 16'h0; d2 = 16'h0;
    for (c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 1) mar = 16'h0042;
      if (c == 6) mem_req = 1'b0;
      if (r_w[0]) begin
        p_cnt++;
        if (p_cnt == 1) begin t1 = c; d1 = rdata_w[0]; end
        if (p_cnt == 2) begin t2 = c; d2 = rdata_w[0]; end
      end
    end
    check_eq("b2b_pulses", p_cnt, 2);
    check_eq("b2b_first_t", t1, 4);
    check_eq("b2b_first_d", d1, 16'h1234);
    check_eq("b2b_second_t", t2, 9);
    check_eq("b2b_second_d", d2, 16'hBEEF);
    exp_rd[0] = 16'hBEEF; exp_rd[1] = 16'hBEEF; exp_rd[2] = 16'h1234;
    for (int i = 0; i < 3; i++) check_eq($sformatf("b2b_hold[%0d]", i), rdata_w[i], exp_rd[i]);
    $display("txn b2b pulses=%0d t1=%0d d1=%h t2=%0d d2=%h", p_cnt, t1, d1, t2, d2);

    // Reset asserted in the middle of a write access
    mem_req = 1'b1; mem_we = 1'b1; mar = 16'h0077; mdr = 16'h5A5A;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("mid_pre[%0d]", i), {we_w[i], ce_w[i], dqoe_w[i]}, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("mid_post[%0d]", i), {we_w[i], ce_w[i], dqoe_w[i], r_w[i]}, 4'b1100);
      check_eq($sformatf("mid_hex[%0d]", i), hex_w[i], 16'h0000);
      check_eq($sformatf("mid_rdata[%0d]", i), rdata_w[i], 16'h0000);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (r_w[i] || !ce_w[i]) stray++;
    end
    check_eq("post_reset_quiet", stray, 0);
    $display("txn reset_mid_write stray=%0d", stray);
    exp_hex = 16'h0000;
    for (int i = 0; i < 3; i++) exp_rd[i] = 16'h0000;

    // Random reads/writes against the scoreboard
    for (int k = 0; k < 12; k++) begin
      a_r  = addr_tab[$urandom_range(7)];
      we_r = 1'($urandom_range(1));
      sw   = 16'($urandom);
      txn_check(we_r, a_r, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
